// File: rtl/ecdsa_arith_pkg.sv
// Shared constants and types for the ECDSA arithmetic blocks.
// Holds the default operand geometry, FSM state encoding and the P-384 prime.
package ecdsa_arith_pkg;

    localparam int unsigned WIDTH = 384;
    localparam int unsigned LIMB  = 64;
    localparam int unsigned NLIMB = WIDTH / LIMB;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPass1 = 2'd1,
        StPass2 = 2'd2,
        StFin   = 2'd3
    } addsub_state_e;

    // p = 2^384 - 2^128 - 2^96 + 2^32 - 1
    localparam logic [383:0] P384 = {
        32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff,
        32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hfffffffe,
        32'hffffffff, 32'h00000000, 32'h00000000, 32'hffffffff
    };

endpackage

// File: rtl/limb_addsub.sv
// Combinational single-limb adder/subtractor with carry/borrow chaining.
// For sub=1, co_o is the borrow-out of x - y - ci.
module limb_addsub #(
    parameter int unsigned LIMB = 64
) (
    input  logic            sub_i,
    input  logic [LIMB-1:0] x_i,
    input  logic [LIMB-1:0] y_i,
    input  logic            ci_i,
    output logic [LIMB-1:0] y_o,
    output logic            co_o
);

    logic [LIMB:0] sum_w;
    logic [LIMB:0] diff_w;

    always_comb begin
        sum_w  = {1'b0, x_i} + {1'b0, y_i} + {{LIMB{1'b0}}, ci_i};
        diff_w = {1'b0, x_i} - {1'b0, y_i} - {{LIMB{1'b0}}, ci_i};
        y_o    = sub_i ? diff_w[LIMB-1:0] : sum_w[LIMB-1:0];
        co_o   = sub_i ? diff_w[LIMB] : sum_w[LIMB];
    end

endmodule

// File: rtl/mod_addsub.sv
// Multi-cycle modular add/sub: one limb per cycle, raw pass then modulus correction.
// Start/done responder; all outputs registered.
module mod_addsub
    import ecdsa_arith_pkg::*;
#(
    parameter int unsigned WIDTH = ecdsa_arith_pkg::WIDTH,
    parameter int unsigned LIMB  = ecdsa_arith_pkg::LIMB
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic             subtract_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [WIDTH-1:0] in_m_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned NLIMB = WIDTH / LIMB;
    localparam int unsigned CntW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NLIMB - 1);

    addsub_state_e    state_q;
    logic [CntW-1:0]  cnt_q;
    logic             c_q, c1_q, c2_q, sub_q;
    logic [WIDTH-1:0] a_q, b_q, m_q, s_q, t_q, result_q;
    logic             done_q, busy_q;

    logic             op_sub;
    logic [LIMB-1:0]  op_x, op_y, limb_y;
    logic             limb_co;
    logic             last;
    logic [WIDTH-1:0] s_rot, t_full;
    logic             pick_t;

    // Pass 2 reuses the same limb unit with the opposite operation on s and m.
    always_comb begin
        if (state_q == StPass2) begin
            op_sub = ~sub_q;
            op_x   = s_q[LIMB-1:0];
            op_y   = m_q[LIMB-1:0];
        end else begin
            op_sub = sub_q;
            op_x   = a_q[LIMB-1:0];
            op_y   = b_q[LIMB-1:0];
        end
        last   = (cnt_q == CntLast);
        s_rot  = {s_q[LIMB-1:0], s_q[WIDTH-1:LIMB]};
        t_full = {limb_y, t_q[WIDTH-1:LIMB]};
        pick_t = sub_q ? c1_q : (c1_q | ~limb_co);
    end

    limb_addsub #(
        .LIMB (LIMB)
    ) u_limb (
        .sub_i (op_sub),
        .x_i   (op_x),
        .y_i   (op_y),
        .ci_i  (c_q),
        .y_o   (limb_y),
        .co_o  (limb_co)
    );

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            c1_q     <= 1'b0;
            c2_q     <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            s_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= in_a_i;
                        b_q     <= in_b_i;
                        m_q     <= in_m_i;
                        sub_q   <= subtract_i;
                        cnt_q   <= '0;
                        c_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StPass1;
                    end
                end
                StPass1: begin
                    // s fills from the top so limb 0 lands at the bottom after NLIMB shifts.
                    s_q <= {limb_y, s_q[WIDTH-1:LIMB]};
                    a_q <= a_q >> LIMB;
                    b_q <= b_q >> LIMB;
                    if (last) begin
                        c1_q    <= limb_co;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StPass2;
                    end else begin
                        c_q   <= limb_co;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPass2: begin
                    // s and m rotate so both are intact again after the pass.
                    s_q <= s_rot;
                    m_q <= {m_q[LIMB-1:0], m_q[WIDTH-1:LIMB]};
                    t_q <= t_full;
                    if (last) begin
                        c2_q     <= sub_q ? 1'b0 : limb_co;
                        c_q      <= 1'b0;
                        cnt_q    <= '0;
                        result_q <= pick_t ? t_full : s_rot;
                        done_q   <= 1'b1;
                        state_q  <= StFin;
                    end else begin
                        c_q   <= limb_co;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFin: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_mod_addsub.sv
// Directed bench for mod_addsub: arithmetic vectors, handshake timing and mid-op reset.
module tb_mod_addsub;
    import ecdsa_arith_pkg::*;

    localparam int unsigned W = 384;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic [W-1:0] result;
    logic         done, busy;

    int n_tests = 0;
    int n_fail  = 0;

    mod_addsub #(
        .WIDTH (W),
        .LIMB  (64)
    ) dut (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .start_i    (start),
        .subtract_i (subtract),
        .in_a_i     (in_a),
        .in_b_i     (in_b),
        .in_m_i     (in_m),
        .result_o   (result),
        .done_o     (done),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to done; cycle 1 is the cycle after the accepting edge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input logic sub, input logic [W-1:0] exp);
        int cyc;
        int bcnt;
        @(negedge clk);
        in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_a = '1; in_b = '1; in_m = '0; subtract = ~sub;
        cyc = 1;
        bcnt = 0;
        while (cyc <= 30) begin
            if (busy) bcnt++;
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, W'(cyc), W'(13));
        check({tag, "_busy"}, W'(bcnt), W'(13));
        check({tag, "_res"}, result, exp);
        @(negedge clk);
        check({tag, "_idle"}, {busy, done}, '0);
    endtask

    initial begin
        logic [W-1:0] one64;
        logic [W-1:0] one128;
        logic [W-1:0] last_res;
        int           ndone;
        int           dcyc [3];
        logic [W-1:0] dres [3];

        one64  = W'(1) << 64;
        one128 = W'(1) << 128;

        repeat (3) @(negedge clk);
        check("rst_result", result, '0);
        check("rst_done", W'(done), '0);
        check("rst_busy", W'(busy), '0);
        resetn = 1'b1;

        run_op("add_1_1", W'(1), W'(1), P384, 1'b0, W'(2));
        run_op("add_wrap", P384 - 1, W'(1), P384, 1'b0, '0);
        run_op("add_c1", P384 - 1, P384 - 1, P384, 1'b0, P384 - 2);
        run_op("sub_neg", '0, W'(1), P384, 1'b1, P384 - 1);
        run_op("sub_zero", W'(5), W'(5), P384, 1'b1, '0);
        run_op("sub_7_3", W'(7), W'(3), P384, 1'b1, W'(4));
        run_op("add_limb", one64 - 1, W'(1), P384, 1'b0, one64);
        run_op("sub_limb", one128, W'(1), P384, 1'b1, one128 - 1);

        // Restarts at cycles 3 and 13 (the done cycle) must be ignored.
        @(negedge clk);
        in_a = W'(100); in_b = W'(23); in_m = P384; subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        last_res = '0;
        for (int c = 1; c <= 28; c++) begin
            if (c == 3 || c == 13) begin
                in_a = W'(9); in_b = W'(9); subtract = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                last_res = result;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("hs_ndone", W'(ndone), W'(1));
        check("hs_res", last_res, W'(123));
        check("hs_busy", W'(busy), '0);

        // Start held high: back-to-back operations, operands advanced at each done.
        in_a = W'(10); in_b = W'(1); in_m = P384; subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        ndone = 0;
        for (int c = 1; c <= 50 && ndone < 3; c++) begin
            if (done) begin
                dcyc[ndone] = c;
                dres[ndone] = result;
                ndone++;
                in_a = W'(10 * (ndone + 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("held_ndone", W'(ndone), W'(3));
        if (ndone == 3) begin
            check("held_gap0", W'(dcyc[1] - dcyc[0]), W'(14));
            check("held_gap1", W'(dcyc[2] - dcyc[1]), W'(14));
            check("held_res0", dres[0], W'(11));
            check("held_res1", dres[1], W'(21));
            check("held_res2", dres[2], W'(31));
        end
        repeat (16) @(negedge clk);

        // Reset at cycle 7 drops the request and clears outputs.
        check("pre_rst_res", result, W'(31));
        in_a = W'(40); in_b = W'(2); subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("mrst_result", result, '0);
        check("mrst_done", W'(done), '0);
        check("mrst_busy", W'(busy), '0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("mrst_quiet", W'(ndone), '0);
        run_op("post_rst", W'(40), W'(2), P384, 1'b1, W'(38));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
